// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the vectored interrupt controller:
//   - irq_state_e    : request FSM states (IDLE, REQ)
//   - DEF_VEC_BASE   : default handler vector of channel 0
//   - DEF_VEC_STRIDE : default address step between channel vectors
//   - calc_idw()     : width of a channel number, max(1, clog2(n))
// -----------------------------------------------------------------------------
package irq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } irq_state_e;

   localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_1000;
   localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

   // A single channel still needs a 1-bit id so int_id never collapses to 0 width.
   function automatic int calc_idw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/irq_controller_if.sv
// -----------------------------------------------------------------------------
// irq_controller_if
// CPU-side request/acknowledge bundle of the interrupt controller.
//   int_en   : CPU global interrupt enable            (CPU -> controller)
//   int_ack  : one-cycle pulse, current request taken (CPU -> controller)
//   eret     : one-cycle pulse, handler returned      (CPU -> controller)
//   int_req  : interrupt request                      (controller -> CPU)
//   int_id   : channel number of the request          (controller -> CPU)
//   int_vec  : handler address of int_id              (controller -> CPU)
// modport master : the controller side; modport slave : the CPU side.
// IDW and VEC_WIDTH must match the controller instance this bundle connects to.
// -----------------------------------------------------------------------------
interface irq_controller_if #(
   parameter int IDW       = 2,
   parameter int VEC_WIDTH = 32
) ();

   logic                 int_en;
   logic                 int_ack;
   logic                 eret;
   logic                 int_req;
   logic [IDW-1:0]       int_id;
   logic [VEC_WIDTH-1:0] int_vec;

   modport master (
      input  int_en, int_ack, eret,
      output int_req, int_id, int_vec
   );

   modport slave (
      output int_en, int_ack, eret,
      input  int_req, int_id, int_vec
   );

endinterface

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// One channel's input conditioning: a SYNC_STAGES-deep synchroniser for an
// asynchronous request line followed by a registered rising-edge detector.
//   clk     : system clock
//   rst     : synchronous reset, active-low
//   irq_raw : raw asynchronous request line
//   level   : synchronised level (last synchroniser stage)
//   rise    : one-cycle pulse, registered, after a synchronised 0->1 transition
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic irq_raw,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   rise_q, rise_d;

   always_comb begin
      // NOTE: every always_comb output gets a value on entry, so no path can infer a latch.
      sync_d = {sync_q[SYNC_STAGES-2:0], irq_raw};
      prev_d = sync_q[SYNC_STAGES-1];
      rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: flops take non-blocking assignments so all of them update from pre-edge values.
      if (!rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = rise_q;

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Vectored interrupt controller for N_IRQ raw request lines. Each channel is
// synchronised, latched as edge- or level-pending, masked, and arbitrated by
// fixed priority (channel N_IRQ-1 highest) with nesting against the
// in-service register. One request at a time is offered to the CPU through
// the req/ack handshake; eret retires the most recent (highest) handler.
//   clk        : system clock
//   rst        : synchronous reset, active-low
//   irq_in     : raw asynchronous request lines
//   level_mode : per channel, 1 = level-sensitive, 0 = rising-edge
//   mask       : per channel, 1 = enabled
//   cpu        : CPU handshake bundle (int_en, int_ack, eret, int_req, int_id, int_vec)
//   pending    : latched / level pending bits
//   in_service : handlers currently active
// -----------------------------------------------------------------------------
module irq_controller
   import irq_pkg::*;
#(
   parameter int                   N_IRQ       = 4,
   parameter int                   VEC_WIDTH   = 32,
   parameter logic [VEC_WIDTH-1:0] VEC_BASE    = VEC_WIDTH'(DEF_VEC_BASE),
   parameter logic [VEC_WIDTH-1:0] VEC_STRIDE  = VEC_WIDTH'(DEF_VEC_STRIDE),
   parameter int                   SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_IRQ-1:0]     irq_in,
   input  logic [N_IRQ-1:0]     level_mode,
   input  logic [N_IRQ-1:0]     mask,
   irq_controller_if.master     cpu,
   output logic [N_IRQ-1:0]     pending,
   output logic [N_IRQ-1:0]     in_service
);

   localparam int IDW = calc_idw(N_IRQ);

   logic [N_IRQ-1:0] sync_level;
   logic [N_IRQ-1:0] sync_rise;

   logic [N_IRQ-1:0] pending_q,    pending_d;
   logic [N_IRQ-1:0] in_service_q, in_service_d;
   logic [IDW-1:0]   int_id_q,     int_id_d;
   irq_state_e       state_q,      state_d;

   logic [N_IRQ-1:0] eligible;
   logic [IDW-1:0]   top_id;
   logic             any_eligible;
   logic [N_IRQ-1:0] isr_top_hot;
   logic [N_IRQ-1:0] ack_hot;
   logic             ack_taken;

   // ---------------------------------------------------------------- inputs
   for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
      irq_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk     (clk),
         .rst     (rst),
         .irq_raw (irq_in[g]),
         .level   (sync_level[g]),
         .rise    (sync_rise[g])
      );
   end

   // ----------------------------------------------------------- arbitration
   // Scanning down from the top, the first in-service channel blocks itself
   // and everything below it; only strictly higher channels may nest.
   always_comb begin : blk_eligible
      logic above_isr;
      above_isr = 1'b1;
      eligible  = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (in_service_q[i]) begin
            above_isr = 1'b0;
         end
         eligible[i] = pending_q[i] & mask[i] & above_isr;
      end
   end

   // Ascending scan: the last hit is the highest index.
   always_comb begin
      top_id       = '0;
      any_eligible = 1'b0;
      isr_top_hot  = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         if (eligible[i]) begin
            top_id       = IDW'(i);
            any_eligible = 1'b1;
         end
         if (in_service_q[i]) begin
            isr_top_hot    = '0;
            isr_top_hot[i] = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------- FSM
   // An ack wins over a withdrawal in the same cycle: the CPU has already
   // committed to the offered id.
   always_comb begin
      state_d   = state_q;
      int_id_d  = int_id_q;
      ack_taken = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cpu.int_en && any_eligible) begin
               state_d  = REQ;
               int_id_d = top_id;
            end
         end
         REQ: begin
            if (cpu.int_ack) begin
               ack_taken = 1'b1;
               state_d   = IDLE;
            end else if (!cpu.int_en || !any_eligible) begin
               state_d = IDLE;
            end else begin
               int_id_d = top_id;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------- pending / in-service
   always_comb begin
      ack_hot = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         ack_hot[i] = ack_taken && (int_id_q == IDW'(i));
      end
   end

   // A fresh edge in the ack cycle keeps the bit set; level channels simply
   // follow the synchronised line and ignore the ack.
   always_comb begin
      pending_d = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         pending_d[i] = level_mode[i] ? sync_level[i]
                                      : (sync_rise[i] | (pending_q[i] & ~ack_hot[i]));
      end
   end

   // eret retires the highest pre-cycle bit before the ack's bit is added,
   // so a simultaneous eret and ack both take effect.
   always_comb begin
      in_service_d = in_service_q;
      if (cpu.eret) begin
         in_service_d = in_service_d & ~isr_top_hot;
      end
      in_service_d = in_service_d | ack_hot;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         int_id_q     <= '0;
         pending_q    <= '0;
         in_service_q <= '0;
      end else begin
         state_q      <= state_d;
         int_id_q     <= int_id_d;
         pending_q    <= pending_d;
         in_service_q <= in_service_d;
      end
   end

   // --------------------------------------------------------------- outputs
   // int_id is zero-extended to VEC_WIDTH so the vector wraps at VEC_WIDTH.
   assign cpu.int_req  = (state_q == REQ);
   assign cpu.int_id   = int_id_q;
   assign cpu.int_vec  = VEC_BASE + VEC_WIDTH'(int_id_q) * VEC_STRIDE;
   assign pending      = pending_q;
   assign in_service   = in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
// Self-checking bench for irq_controller (4 channels, 2 sync stages).
// A reference model updates on every rising edge and queues the expected
// outputs; a monitor pops one entry per falling edge and compares. Directed
// scenarios add constant checks for latencies, vectors and reset; a random
// phase follows.
// -----------------------------------------------------------------------------
module tb_irq_controller;

   localparam int N   = 4;
   localparam int S   = 2;
   localparam int IDW = irq_pkg::calc_idw(N);

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] irq_in;
   logic [N-1:0] level_mode;
   logic [N-1:0] mask;
   logic [N-1:0] pending;
   logic [N-1:0] in_service;

   irq_controller_if #(.IDW(IDW), .VEC_WIDTH(32)) cpu_if ();

   irq_controller #(
      .N_IRQ       (N),
      .VEC_WIDTH   (32),
      .VEC_BASE    (32'h0000_1000),
      .VEC_STRIDE  (32'h0000_0010),
      .SYNC_STAGES (S)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_in     (irq_in),
      .level_mode (level_mode),
      .mask       (mask),
      .cpu        (cpu_if),
      .pending    (pending),
      .in_service (in_service)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------- reference model
   typedef struct {
      logic         req;
      int           id;
      logic [31:0]  vec;
      logic [N-1:0] pend;
      logic [N-1:0] isvc;
   } exp_t;

   exp_t         exp_q[$];
   logic [N-1:0] m_hist [0:S+1];   // m_hist[0] = irq_in sampled at the latest edge
   logic [N-1:0] m_pend;
   int           m_stack[$];       // active handlers, innermost last
   logic         m_req;
   int           m_id;

   always @(posedge clk) begin : ref_model
      exp_t         e;
      int           top;
      int           best;
      logic         taken;
      logic [N-1:0] synced;
      logic [N-1:0] rise;
      logic [N-1:0] isvc;
      if (!rst) begin
         for (int j = 0; j <= S + 1; j++) m_hist[j] = '0;
         m_pend = '0;
         m_stack.delete();
         m_req  = 1'b0;
         m_id   = 0;
      end else begin
         top  = (m_stack.size() > 0) ? m_stack[$] : -1;
         best = -1;
         for (int i = 0; i < N; i++)
            if (m_pend[i] && mask[i] && i > top) best = i;
         taken  = m_req && cpu_if.int_ack;
         synced = m_hist[S-1];
         rise   = m_hist[S] & ~m_hist[S+1];
         for (int i = 0; i < N; i++) begin
            if (level_mode[i]) m_pend[i] = synced[i];
            else m_pend[i] = rise[i] | (m_pend[i] & !(taken && m_id == i));
         end
         if (cpu_if.eret && m_stack.size() > 0) void'(m_stack.pop_back());
         if (taken) m_stack.push_back(m_id);
         if (!m_req) begin
            if (cpu_if.int_en && best >= 0) begin
               m_req = 1'b1;
               m_id  = best;
            end
         end else if (taken || !cpu_if.int_en || best < 0) begin
            m_req = 1'b0;
         end else begin
            m_id = best;
         end
         for (int j = S + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = irq_in;
      end
      isvc = '0;
      foreach (m_stack[k]) isvc[m_stack[k]] = 1'b1;
      e.req  = m_req;
      e.id   = m_id;
      e.vec  = 32'h0000_1000 + 32'(m_id) * 32'h0000_0010;
      e.pend = m_pend;
      e.isvc = isvc;
      exp_q.push_back(e);
   end

   // --------------------------------------------------------------- monitor
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("model_req", cpu_if.int_req, e.req);
         if (e.req) begin
            check("model_id",  cpu_if.int_id,  e.id);
            check("model_vec", cpu_if.int_vec, e.vec);
         end
         check("model_pending",    pending,    e.pend);
         check("model_in_service", in_service, e.isvc);
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic pulse_ack();
      cpu_if.int_ack = 1'b1;
      @(negedge clk);
      cpu_if.int_ack = 1'b0;
   endtask

   task automatic pulse_eret();
      cpu_if.eret = 1'b1;
      @(negedge clk);
      cpu_if.eret = 1'b0;
   endtask

   // Raise the given lines for one cycle, then count falling edges until int_req.
   task automatic pulse_wait(input logic [N-1:0] bits, output int cnt);
      irq_in = irq_in | bits;
      cnt    = 0;
      while (!cpu_if.int_req && cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) irq_in = irq_in & ~bits;
      end
      irq_in = irq_in & ~bits;
   endtask

   // Behave as a CPU that takes and retires everything until idle.
   task automatic drain();
      for (int c = 0; c < 30; c++) begin
         cpu_if.int_ack = cpu_if.int_req;
         cpu_if.eret    = !cpu_if.int_req && (in_service != '0);
         @(negedge clk);
      end
      cpu_if.int_ack = 1'b0;
      cpu_if.eret    = 1'b0;
   endtask

   initial begin : stim
      int   cnt;
      logic stayed;
      rst            = 1'b0;
      irq_in         = '0;
      level_mode     = '0;
      mask           = 4'hF;
      cpu_if.int_en  = 1'b1;
      cpu_if.int_ack = 1'b0;
      cpu_if.eret    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_req",  cpu_if.int_req, 1'b0);
      check("reset_vec",  cpu_if.int_vec, 32'h0000_1000);
      check("reset_pend", pending, 4'b0000);
      rst = 1'b1;
      @(negedge clk);

      // Edge request on ch1: latency, vector, ack.
      pulse_wait(4'b0010, cnt);
      check("edge_latency", cnt, 5);
      check("ch1_id",  cpu_if.int_id,  1);
      check("ch1_vec", cpu_if.int_vec, 32'h0000_1010);
      pulse_ack();
      check("ack_req_low", cpu_if.int_req, 1'b0);
      check("ack_isvc",    in_service, 4'b0010);
      check("ack_pend",    pending, 4'b0000);

      // Nesting: ch0 blocked, ch3 pre-empts.
      pulse_wait(4'b1001, cnt);
      check("nest_id",   cpu_if.int_id,  3);
      check("nest_vec",  cpu_if.int_vec, 32'h0000_1030);
      check("nest_pend", pending, 4'b1001);
      pulse_ack();
      check("nest_isvc", in_service, 4'b1010);
      pulse_eret();
      check("eret1_isvc", in_service, 4'b0010);
      @(negedge clk);
      check("ch0_blocked", cpu_if.int_req, 1'b0);
      cpu_if.eret = 1'b1;
      cnt = 0;
      while (!cpu_if.int_req && cnt < 20) begin
         @(negedge clk);
         cnt++;
         cpu_if.eret = 1'b0;
      end
      check("eret_latency", cnt, 2);
      check("ch0_vec", cpu_if.int_vec, 32'h0000_1000);
      drain();

      // Pre-emption before ack.
      pulse_wait(4'b0010, cnt);
      check("pre_id1", cpu_if.int_id, 1);
      irq_in[2] = 1'b1;
      cnt    = 0;
      stayed = 1'b1;
      while (cpu_if.int_id != 2 && cnt < 20) begin
         @(negedge clk);
         cnt++;
         irq_in[2] = 1'b0;
         if (!cpu_if.int_req) stayed = 1'b0;
      end
      check("pre_id2",    cpu_if.int_id,  2);
      check("pre_vec",    cpu_if.int_vec, 32'h0000_1020);
      check("pre_req_hi", stayed, 1'b1);
      drain();

      // Level mode on ch2.
      level_mode = 4'b0100;
      irq_in[2]  = 1'b1;
      cnt = 0;
      while (!cpu_if.int_req && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("lvl_id", cpu_if.int_id, 2);
      pulse_ack();
      check("lvl_ack_req",  cpu_if.int_req, 1'b0);
      check("lvl_ack_pend", pending, 4'b0100);
      pulse_eret();
      cnt = 0;
      while (!cpu_if.int_req && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("lvl_rereq", cpu_if.int_id, 2);
      irq_in[2] = 1'b0;
      cnt = 0;
      while (cpu_if.int_req && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("lvl_withdraw", cpu_if.int_req, 1'b0);
      level_mode = '0;
      drain();

      // Masking and global enable.
      mask      = 4'b0000;
      irq_in[1] = 1'b1;
      @(negedge clk);
      irq_in[1] = 1'b0;
      repeat (8) @(negedge clk);
      check("mask_noreq", cpu_if.int_req, 1'b0);
      check("mask_pend",  pending, 4'b0010);
      mask[1] = 1'b1;
      @(negedge clk);
      check("unmask_req", cpu_if.int_req, 1'b1);
      cpu_if.int_en = 1'b0;
      @(negedge clk);
      check("inten_drop", cpu_if.int_req, 1'b0);
      cpu_if.int_en = 1'b1;
      mask          = 4'hF;
      drain();

      // Reset mid-handler and mid-handshake.
      pulse_wait(4'b0010, cnt);
      pulse_ack();
      pulse_wait(4'b1000, cnt);
      check("prerst_req",  cpu_if.int_req, 1'b1);
      check("prerst_isvc", in_service, 4'b0010);
      rst            = 1'b0;
      cpu_if.int_ack = 1'b1;
      cpu_if.eret    = 1'b1;
      @(negedge clk);
      check("rst_req",  cpu_if.int_req, 1'b0);
      check("rst_id",   cpu_if.int_id, 0);
      check("rst_vec",  cpu_if.int_vec, 32'h0000_1000);
      check("rst_isvc", in_service, 4'b0000);
      check("rst_pend", pending, 4'b0000);
      rst            = 1'b1;
      cpu_if.int_ack = 1'b0;
      cpu_if.eret    = 1'b0;
      @(negedge clk);
      check("postrst_isvc", in_service, 4'b0000);

      // Random phase, checked by the model.
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 399) != 0);
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 9) == 0) irq_in[i] = ~irq_in[i];
         if ($urandom_range(0, 99) == 0) level_mode = N'($urandom);
         if ($urandom_range(0, 49) == 0) mask = N'($urandom) | N'($urandom);
         cpu_if.int_en  = ($urandom_range(0, 19) != 0);
         cpu_if.int_ack = cpu_if.int_req ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 19) == 0);
         cpu_if.eret    = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
